iic_slave_regs: RTL and testbench

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

---
 rtl/iic_slave_regs.sv | 253 +++++++++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regs.sv
// iic_slave_regs: I2C slave that bridges bus transfers onto a simple register port.
//
// Write transfer: DEV(W) + RA-bit register address (MSB byte first) + data bytes.
// Each data byte produces one wr_en strobe at reg_addr. reg_addr then increments.
// Read transfer: DEV(R) streams bytes fetched with rd_en from reg_addr. Each master
// ACK increments reg_addr and fetches the next byte.
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   iic_scl      bus clock from master (asynchronous, synchronized here)
//   iic_sda      open-drain bus data (driven 1'b0 or Z only)
//   reg_addr     current register address (RA = 8+8*IIC_SLAVE_REG_EX bits)
//   wr_en        write strobe, wr_data valid with it
//   rd_en        read request for reg_addr, rd_data sampled 2 clk edges later
//   busy         high from START until STOP
//   state_dbg    current FSM state encoding
//
// Strobe protocol: wr_en and rd_en are single-clock pulses with no back-pressure.
// The register side must accept a write in the cycle wr_en is high. For a read it
// must present rd_data by the clock edge that follows the cycle in which rd_en
// was high. A registered read that responds to rd_en meets this.
module iic_slave_regs #(
   parameter int         CLK_FRE          = 50,
   parameter int         IIC_FRE          = 100,
   parameter logic [6:0] IIC_SLAVE_ADDR   = 7'h3C,
   parameter int         IIC_SLAVE_REG_EX = 1,
   localparam int        RA               = 8 + 8 * IIC_SLAVE_REG_EX
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iic_scl,
   inout  wire           iic_sda,
   output logic [RA-1:0] reg_addr,
   output logic          wr_en,
   output logic [7:0]    wr_data,
   output logic          rd_en,
   input  logic [7:0]    rd_data,
   output logic          busy,
   output logic [3:0]    state_dbg
);

   if (CLK_FRE * 1000 / IIC_FRE < 40) begin : g_ratio_check
      $error("iic_slave_regs: CLK_FRE*1000/IIC_FRE must be >= 40");
   end

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      DEV_ADDR  = 4'd1,
      ACK_DEV   = 4'd2,
      REG_ADDR  = 4'd3,
      ACK_REG   = 4'd4,
      WR_DATA   = 4'd5,
      ACK_WR    = 4'd6,
      RD_DATA   = 4'd7,
      RD_ACK    = 4'd8,
      WAIT_STOP = 4'd9
   } state_t;

   localparam logic [RA-1:0] ONE       = RA'(1);
   localparam logic [3:0]    LAST_BYTE = 4'(IIC_SLAVE_REG_EX);

   // Synchronizers plus history stage. They reset to the idle bus level so
   // that leaving reset creates no false START or STOP.
   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
         sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
      end else begin
         scl_s1 <= iic_scl; scl_s2 <= scl_s1; scl_d <= scl_s2;
         sda_s1 <= iic_sda; sda_s2 <= sda_s1; sda_d <= sda_s2;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  =  scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 &  scl_d;
   assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
   assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

   state_t        state, state_nxt;
   logic [3:0]    bit_cnt, bit_cnt_nxt;
   logic [3:0]    byte_cnt, byte_cnt_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [RA-1:0] addr_shift, addr_shift_nxt;
   logic [RA-1:0] reg_addr_nxt;
   logic [7:0]    wr_data_nxt;
   logic          rw, rw_nxt;
   logic          sda_oe, sda_oe_nxt;
   logic          wr_en_nxt, rd_en_nxt;
   logic          rd_load, rd_load_nxt;
   logic          rx_done;

   assign rx_done = scl_fall && (bit_cnt == 4'd8);

   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      byte_cnt_nxt   = byte_cnt;
      shift_nxt      = shift;
      addr_shift_nxt = addr_shift;
      reg_addr_nxt   = reg_addr;
      wr_data_nxt    = wr_data;
      rw_nxt         = rw;
      sda_oe_nxt     = sda_oe;
      wr_en_nxt      = 1'b0;
      rd_en_nxt      = 1'b0;
      rd_load_nxt    = rd_en;

      // STOP and START override every state. A partial byte is simply dropped.
      if (stop_det) begin
         state_nxt   = IDLE;
         sda_oe_nxt  = 1'b0;
         bit_cnt_nxt = 4'd0;
      end else if (start_det) begin
         state_nxt   = DEV_ADDR;
         sda_oe_nxt  = 1'b0;
         bit_cnt_nxt = 4'd0;
      end else begin
         case (state)
            IDLE: ;
            DEV_ADDR, REG_ADDR, WR_DATA: begin
               if (scl_rise) begin
                  shift_nxt   = {shift[6:0], sda_s2};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (rx_done) begin
                  bit_cnt_nxt = 4'd0;
                  sda_oe_nxt  = 1'b1;
                  if (state == DEV_ADDR) begin
                     rw_nxt = shift[0];
                     if (shift[7:1] == IIC_SLAVE_ADDR) begin
                        state_nxt = ACK_DEV;
                     end else begin
                        state_nxt  = WAIT_STOP;
                        sda_oe_nxt = 1'b0;
                     end
                  end else if (state == REG_ADDR) begin
                     addr_shift_nxt = (addr_shift << 8) | RA'(shift);
                     state_nxt      = ACK_REG;
                  end else begin
                     // reg_addr is still the target address while wr_en is high.
                     wr_en_nxt   = 1'b1;
                     wr_data_nxt = shift;
                     state_nxt   = ACK_WR;
                  end
               end
            end
            ACK_DEV: begin
               if (scl_rise && rw) begin
                  rd_en_nxt = 1'b1;
               end else if (scl_fall) begin
                  if (rw) begin
                     state_nxt  = RD_DATA;
                     sda_oe_nxt = ~shift[7];
                  end else begin
                     state_nxt    = REG_ADDR;
                     sda_oe_nxt   = 1'b0;
                     byte_cnt_nxt = 4'd0;
                  end
               end
            end
            ACK_REG: begin
               if (scl_fall) begin
                  sda_oe_nxt = 1'b0;
                  if (byte_cnt == LAST_BYTE) begin
                     reg_addr_nxt = addr_shift;
                     state_nxt    = WR_DATA;
                  end else begin
                     byte_cnt_nxt = byte_cnt + 4'd1;
                     state_nxt    = REG_ADDR;
                  end
               end
            end
            ACK_WR: begin
               if (scl_fall) begin
                  sda_oe_nxt = 1'b0;
                  state_nxt  = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (rx_done) begin
                  bit_cnt_nxt = 4'd0;
                  sda_oe_nxt  = 1'b0;
                  state_nxt   = RD_ACK;
               end else if (scl_fall) begin
                  shift_nxt  = {shift[6:0], 1'b0};
                  sda_oe_nxt = ~shift[6];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s2) begin
                     state_nxt = WAIT_STOP;
                  end else begin
                     reg_addr_nxt = reg_addr + ONE;
                     rd_en_nxt    = 1'b1;
                  end
               end else if (scl_fall) begin
                  // A NACK has already left this state, so reaching here means ACK.
                  state_nxt  = RD_DATA;
                  sda_oe_nxt = ~shift[7];
               end
            end
            WAIT_STOP: ;
            default: state_nxt = IDLE;
         endcase
      end

      // Post-write increment happens on the clock after the strobe. Read data
      // is captured on the clock after rd_en.
      if (wr_en) reg_addr_nxt = reg_addr + ONE;
      if (rd_load) shift_nxt = rd_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         byte_cnt   <= 4'd0;
         shift      <= 8'd0;
         addr_shift <= '0;
         reg_addr   <= '0;
         wr_data    <= 8'd0;
         rw         <= 1'b0;
         sda_oe     <= 1'b0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         rd_load    <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         byte_cnt   <= byte_cnt_nxt;
         shift      <= shift_nxt;
         addr_shift <= addr_shift_nxt;
         reg_addr   <= reg_addr_nxt;
         wr_data    <= wr_data_nxt;
         rw         <= rw_nxt;
         sda_oe     <= sda_oe_nxt;
         wr_en      <= wr_en_nxt;
         rd_en      <= rd_en_nxt;
         rd_load    <= rd_load_nxt;
      end
   end

   assign iic_sda   = sda_oe ? 1'b0 : 1'bz;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_iic_slave_regs.sv
`timescale 1ns/1ps
module tb_iic_slave_regs;

   localparam int Q = 13;  // quarter I2C bit period in clk cycles

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   wire         sda_bus;
   logic [15:0] reg_addr;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        rd_en;
   logic [7:0]  rd_data = 8'd0;
   logic        busy;
   logic [3:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [23:0] exp_q[$];
   logic [23:0] wr_log[$];
   logic [15:0] rd_log[$];
   int          both_cnt = 0;
   int          wr_wide  = 0;
   int          rd_wide  = 0;
   logic        wr_en_q  = 1'b0;
   logic        rd_en_q  = 1'b0;
   logic        ack;
   logic [7:0]  rbyte;

   // clock / reset / bus
   always #10 clk = ~clk;
   assign sda_bus = sda_m ? 1'bz : 1'b0;
   pullup (sda_bus);

   iic_slave_regs #(
      .CLK_FRE(50), .IIC_FRE(1000), .IIC_SLAVE_ADDR(7'h3C), .IIC_SLAVE_REG_EX(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .iic_scl(scl_m), .iic_sda(sda_bus),
      .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .busy(busy), .state_dbg(state_dbg)
   );

   // registered register-file model for reads
   always @(posedge clk) begin
      if (rd_en)
         rd_data <= (reg_addr == 16'h1234) ? 8'hA5 :
                    (reg_addr == 16'h1235) ? 8'h3C : 8'hEE;
   end

   // strobe monitor
   always @(negedge clk) begin
      if (wr_en) wr_log.push_back({reg_addr, wr_data});
      if (rd_en) rd_log.push_back(reg_addr);
      if (wr_en && rd_en) both_cnt <= both_cnt + 1;
      if (wr_en && wr_en_q) wr_wide <= wr_wide + 1;
      if (rd_en && rd_en_q) rd_wide <= rd_wide + 1;
      wr_en_q <= wr_en;
      rd_en_q <= rd_en;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic wait_q(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      sda_m = 1'b0; wait_q(Q);
      scl_m = 1'b0; wait_q(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      sda_m = 1'b1; wait_q(Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wait_q(Q);
      scl_m = 1'b1; wait_q(2 * Q);
      scl_m = 1'b0; wait_q(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; wait_q(Q);
      scl_m = 1'b1; wait_q(Q);
      a = sda_bus;  wait_q(Q);
      scl_m = 1'b0; wait_q(Q);
   endtask

   task automatic send_chk(input string tag, input logic [7:0] b);
      logic a;
      send_byte(b, a);
      check(tag, a, 1'b0);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      sda_m = 1'b1;
      d = 8'd0;
      for (int i = 0; i < 8; i++) begin
         wait_q(Q);
         scl_m = 1'b1; wait_q(Q);
         d = {d[6:0], sda_bus}; wait_q(Q);
         scl_m = 1'b0; wait_q(Q);
      end
      send_bit(~m_ack);
   endtask

   // scoreboard: compare logged writes against the expected queue
   task automatic check_writes(input string tag);
      check({tag, " count"}, wr_log.size(), exp_q.size());
      while (exp_q.size() > 0 && wr_log.size() > 0)
         check(tag, wr_log.pop_front(), exp_q.pop_front());
      exp_q.delete();
      wr_log.delete();
   endtask

   initial begin
      // reset state
      rst_n = 1'b0; wait_q(5);
      check("rst reg_addr", reg_addr, 16'h0000);
      check("rst wr_en", wr_en, 1'b0);
      check("rst wr_data", wr_data, 8'h00);
      check("rst rd_en", rd_en, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst sda", sda_bus, 1'b1);
      check("rst state", state_dbg, 4'd0);
      rst_n = 1'b1; wait_q(5);

      // single write 0x3008 <= 0x82
      i2c_start();
      check("t1 busy", busy, 1'b1);
      send_chk("t1 dev ack", 8'h78);
      send_chk("t1 ra_hi ack", 8'h30);
      check("t1 reg_addr held", reg_addr, 16'h0000);
      send_chk("t1 ra_lo ack", 8'h08);
      send_chk("t1 data ack", 8'h82);
      exp_q.push_back({16'h3008, 8'h82});
      i2c_stop();
      check_writes("t1 wr");
      check("t1 reg_addr", reg_addr, 16'h3009);
      check("t1 busy after stop", busy, 1'b0);

      // burst write wrapping at 0xFFFF
      i2c_start();
      send_chk("t2 dev ack", 8'h78);
      send_chk("t2 ra_hi ack", 8'hFF);
      send_chk("t2 ra_lo ack", 8'hFF);
      send_chk("t2 d0 ack", 8'h11);
      send_chk("t2 d1 ack", 8'h22);
      exp_q.push_back({16'hFFFF, 8'h11});
      exp_q.push_back({16'h0000, 8'h22});
      i2c_stop();
      check_writes("t2 wr");
      check("t2 reg_addr", reg_addr, 16'h0001);

      // wrong device address
      i2c_start();
      send_byte(8'h84, ack);
      check("t3 nack", ack, 1'b1);
      i2c_stop();
      check_writes("t3 wr");
      check("t3 rd count", rd_log.size(), 0);
      check("t3 busy", busy, 1'b0);

      // set address, repeated START, read two bytes
      i2c_start();
      send_chk("t4 dev ack", 8'h78);
      send_chk("t4 ra_hi ack", 8'h12);
      send_chk("t4 ra_lo ack", 8'h34);
      i2c_start();
      send_chk("t4 devr ack", 8'h79);
      read_byte(1'b1, rbyte);
      check("t4 byte0", rbyte, 8'hA5);
      read_byte(1'b0, rbyte);
      check("t4 byte1", rbyte, 8'h3C);
      wait_q(4);
      check("t4 sda released", sda_bus, 1'b1);
      check("t4 wait_stop", state_dbg, 4'd9);
      i2c_stop();
      check("t4 rd count", rd_log.size(), 2);
      if (rd_log.size() == 2) begin
         check("t4 rd0 addr", rd_log[0], 16'h1234);
         check("t4 rd1 addr", rd_log[1], 16'h1235);
      end
      rd_log.delete();
      check_writes("t4 wr");
      check("t4 reg_addr", reg_addr, 16'h1235);

      // STOP after 5 data bits
      i2c_start();
      send_chk("t5 dev ack", 8'h78);
      send_chk("t5 ra_hi ack", 8'h00);
      send_chk("t5 ra_lo ack", 8'h10);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      check_writes("t5 wr");
      check("t5 reg_addr", reg_addr, 16'h0010);
      check("t5 state", state_dbg, 4'd0);

      // partial byte then repeated START, then a full write
      i2c_start();
      send_chk("t6 dev ack", 8'h78);
      send_chk("t6 ra_hi ack", 8'h00);
      send_chk("t6 ra_lo ack", 8'h20);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      i2c_start();
      send_chk("t6 dev2 ack", 8'h78);
      send_chk("t6 ra2_hi ack", 8'h00);
      send_chk("t6 ra2_lo ack", 8'h21);
      send_chk("t6 data ack", 8'h5A);
      exp_q.push_back({16'h0021, 8'h5A});
      i2c_stop();
      check_writes("t6 wr");
      check("t6 reg_addr", reg_addr, 16'h0022);

      // reset while the slave drives the data ACK
      i2c_start();
      send_chk("t7 dev ack", 8'h78);
      send_chk("t7 ra_hi ack", 8'h00);
      send_chk("t7 ra_lo ack", 8'h40);
      for (int i = 7; i >= 0; i--) send_bit(((8'h66 >> i) & 8'h01) != 8'h00);
      sda_m = 1'b1; wait_q(2);
      check("t7 ack driven", sda_bus, 1'b0);
      check("t7 state ack_wr", state_dbg, 4'd6);
      rst_n = 1'b0; wait_q(1);
      check("t7 rst sda", sda_bus, 1'b1);
      check("t7 rst reg_addr", reg_addr, 16'h0000);
      check("t7 rst wr_data", wr_data, 8'h00);
      check("t7 rst wr_en", wr_en, 1'b0);
      check("t7 rst busy", busy, 1'b0);
      check("t7 rst state", state_dbg, 4'd0);
      exp_q.push_back({16'h0040, 8'h66});
      check_writes("t7 wr");
      rst_n = 1'b1; wait_q(3);
      i2c_stop();
      i2c_start();
      send_chk("t7b dev ack", 8'h78);
      send_chk("t7b ra_hi ack", 8'h00);
      send_chk("t7b ra_lo ack", 8'h50);
      send_chk("t7b data ack", 8'h77);
      exp_q.push_back({16'h0050, 8'h77});
      i2c_stop();
      check_writes("t7b wr");
      check("t7b reg_addr", reg_addr, 16'h0051);

      // strobe integrity across the whole run
      check("wr_en rd_en overlap", both_cnt, 0);
      check("wr_en width", wr_wide, 0);
      check("rd_en width", rd_wide, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
